// File: rtl/rect_outline_gen_pkg.sv
// Shared constants, state encoding and helpers for the rectangle outline generator.
package rect_outline_gen_pkg;

  // Visible screen limits and the off-screen sentinel point.
  localparam logic [15:0] X_LAST = 16'd799;
  localparam logic [15:0] Y_LAST = 16'd599;
  localparam logic [15:0] X_OFF  = 16'd801;
  localparam logic [15:0] Y_OFF  = 16'd601;

  // Drawing modes understood by the controller side.
  localparam logic [1:0] DRAW_LINE = 2'd0;
  localparam logic [1:0] RECTANGLE = 2'd1;
  localparam logic [1:0] TRIANGLE  = 2'd2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHaveA = 3'd1,
    StArmed = 3'd2,
    StEmit  = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rect_outline_gen_point_step.sv
// Combinational successor of an outline point in raster order.
module rect_point_step
  import rect_outline_gen_pkg::*;
(
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic [15:0] i_xmin,
  input  logic [15:0] i_xmax,
  input  logic [15:0] i_ymin,
  input  logic [15:0] i_ymax,
  output logic [15:0] o_nx,
  output logic [15:0] o_ny,
  output logic        o_is_last
);

  logic w_edge_row;

  assign w_edge_row = (i_y == i_ymin) || (i_y == i_ymax);
  assign o_is_last  = (i_x == i_xmax) && (i_y == i_ymax);

  // Edge rows walk every column; middle rows jump from the left side to the right side.
  always_comb begin
    o_nx = i_xmin;
    o_ny = i_y + 16'd1;
    if (w_edge_row && (i_x < i_xmax)) begin
      o_nx = i_x + 16'd1;
      o_ny = i_y;
    end else if (!w_edge_row && (i_x == i_xmin) && (i_xmin != i_xmax)) begin
      o_nx = i_xmax;
      o_ny = i_y;
    end
  end

endmodule

// File: rtl/rect_outline_gen.sv
// Latches two corners, sorts them into a box and presents the outline point by point.
module rect_outline_gen
  import rect_outline_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_x_pos,
  input  logic [15:0] i_y_pos,
  input  logic        rec_start,
  input  logic        enable,
  input  logic        strat_to_output,
  input  logic        renew_start,
  input  logic        new_frame,
  output logic        all_done,
  output logic [15:0] o_x_pos,
  output logic [15:0] o_y_pos
);

  state_e      r_state, w_state_d;
  logic [15:0] r_ax, w_ax_d, r_ay, w_ay_d;
  logic [15:0] r_xmin, w_xmin_d, r_xmax, w_xmax_d;
  logic [15:0] r_ymin, w_ymin_d, r_ymax, w_ymax_d;
  logic [15:0] r_x, w_x_d, r_y, w_y_d;
  logic [15:0] w_cx, w_cy, w_nx, w_ny;
  logic        w_is_last;
  logic        w_can_start;

  assign w_cx = clamp16(i_x_pos, X_LAST);
  assign w_cy = clamp16(i_y_pos, Y_LAST);
  assign w_can_start = (r_state == StArmed) || (r_state == StEmit) || (r_state == StDone);

  rect_point_step u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_xmin   (r_xmin),
    .i_xmax   (r_xmax),
    .i_ymin   (r_ymin),
    .i_ymax   (r_ymax),
    .o_nx     (w_nx),
    .o_ny     (w_ny),
    .o_is_last(w_is_last)
  );

  // Next-state and datapath updates, highest-priority event first.
  always_comb begin
    w_state_d = r_state;
    w_ax_d    = r_ax;
    w_ay_d    = r_ay;
    w_xmin_d  = r_xmin;
    w_xmax_d  = r_xmax;
    w_ymin_d  = r_ymin;
    w_ymax_d  = r_ymax;
    w_x_d     = r_x;
    w_y_d     = r_y;
    if (rec_start) begin
      w_state_d = StHaveA;
      w_ax_d    = w_cx;
      w_ay_d    = w_cy;
    end else if (strat_to_output && w_can_start) begin
      w_state_d = StEmit;
      w_x_d     = r_xmin;
      w_y_d     = r_ymin;
    end else if ((r_state == StEmit) && new_frame) begin
      // Rewind so a missed match never leaves the outline incomplete for a frame.
      w_x_d = r_xmin;
      w_y_d = r_ymin;
    end else if ((r_state == StEmit) && renew_start) begin
      if (w_is_last) begin
        w_state_d = StDone;
      end else begin
        w_x_d = w_nx;
        w_y_d = w_ny;
      end
    end else if ((r_state == StHaveA) && enable) begin
      w_state_d = StArmed;
      w_xmin_d  = (r_ax < w_cx) ? r_ax : w_cx;
      w_xmax_d  = (r_ax < w_cx) ? w_cx : r_ax;
      w_ymin_d  = (r_ay < w_cy) ? r_ay : w_cy;
      w_ymax_d  = (r_ay < w_cy) ? w_cy : r_ay;
    end
  end

  // State, corner, box and current-point registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_ax    <= '0;
      r_ay    <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_d;
      r_ax    <= w_ax_d;
      r_ay    <= w_ay_d;
      r_xmin  <= w_xmin_d;
      r_xmax  <= w_xmax_d;
      r_ymin  <= w_ymin_d;
      r_ymax  <= w_ymax_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
    end
  end

  // Only EMIT exposes a real point; every other state parks the output off-screen.
  always_comb begin
    all_done = (r_state == StDone);
    o_x_pos  = (r_state == StEmit) ? r_x : X_OFF;
    o_y_pos  = (r_state == StEmit) ? r_y : Y_OFF;
  end

endmodule

// File: tb/tb_rect_outline_gen.sv
// Randomized and directed bench for rect_outline_gen against a raster-scan outline model.
module tb_rect_outline_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i_x_pos = '0;
  logic [15:0] i_y_pos = '0;
  logic        rec_start = 1'b0;
  logic        enable = 1'b0;
  logic        strat_to_output = 1'b0;
  logic        renew_start = 1'b0;
  logic        new_frame = 1'b0;
  logic        all_done;
  logic [15:0] o_x_pos;
  logic [15:0] o_y_pos;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rect_outline_gen dut (
    .clk            (clk),
    .rst            (rst),
    .i_x_pos        (i_x_pos),
    .i_y_pos        (i_y_pos),
    .rec_start      (rec_start),
    .enable         (enable),
    .strat_to_output(strat_to_output),
    .renew_start    (renew_start),
    .new_frame      (new_frame),
    .all_done       (all_done),
    .o_x_pos        (o_x_pos),
    .o_y_pos        (o_y_pos)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the clamped bounding box in raster order, keep points on its border.
  task automatic model(input int ax, input int ay, input int bx, input int by);
    int xmin, xmax, ymin, ymax;
    ax = (ax > 799) ? 799 : ax;
    bx = (bx > 799) ? 799 : bx;
    ay = (ay > 599) ? 599 : ay;
    by = (by > 599) ? 599 : by;
    xmin = (ax < bx) ? ax : bx;
    xmax = (ax < bx) ? bx : ax;
    ymin = (ay < by) ? ay : by;
    ymax = (ay < by) ? by : ay;
    exp_q.delete();
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        if (y == ymin || y == ymax || x == xmin || x == xmax) exp_q.push_back({16'(x), 16'(y)});
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, ".x"}, {16'd0, o_x_pos}, 32'd801);
    check_eq({tag, ".y"}, {16'd0, o_y_pos}, 32'd601);
  endtask

  task automatic check_pt(input string tag, input logic [31:0] p);
    check_eq({tag, ".x"}, {16'd0, o_x_pos}, {16'd0, p[31:16]});
    check_eq({tag, ".y"}, {16'd0, o_y_pos}, {16'd0, p[15:0]});
  endtask

  task automatic pulse_rec(input int x, input int y);
    i_x_pos = 16'(x);
    i_y_pos = 16'(y);
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
  endtask

  task automatic pulse_en(input int x, input int y);
    i_x_pos = 16'(x);
    i_y_pos = 16'(y);
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic pulse_start();
    strat_to_output = 1'b1;
    tick();
    strat_to_output = 1'b0;
  endtask

  task automatic pulse_renew();
    renew_start = 1'b1;
    tick();
    renew_start = 1'b0;
  endtask

  task automatic load(input int ax, input int ay, input int bx, input int by);
    model(ax, ay, bx, by);
    pulse_rec(ax, ay);
    check_off("have_a");
    pulse_en(bx, by);
    check_off("armed");
    check_eq("armed.done", {31'd0, all_done}, 32'd0);
    pulse_start();
    check_pt("first", exp_q[0]);
    check_eq("first.done", {31'd0, all_done}, 32'd0);
  endtask

  // Walk the outline from exp_q[start] to the end, optionally with idle gaps between matches.
  task automatic run_pass(input int start, input bit gaps);
    for (int i = start; i < exp_q.size(); i++) begin
      check_pt("pt", exp_q[i]);
      check_eq("pt.done", {31'd0, all_done}, 32'd0);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) tick();
        check_pt("hold", exp_q[i]);
      end
      pulse_renew();
    end
    check_eq("end.done", {31'd0, all_done}, 32'd1);
    check_off("end");
  endtask

  initial begin
    #12;
    check_off("reset");
    check_eq("reset.done", {31'd0, all_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_off("idle");

    // Enable and start are ignored before a corner A exists.
    pulse_en(5, 5);
    pulse_start();
    pulse_renew();
    check_off("idle_ignore");

    load(10, 20, 13, 22);
    run_pass(0, 1'b0);

    // DONE holds through new_frame; a new start replays the same outline.
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check_off("done_nf");
    check_eq("done_nf.done", {31'd0, all_done}, 32'd1);
    pulse_renew();
    check_eq("done_renew.done", {31'd0, all_done}, 32'd1);
    pulse_start();
    check_eq("restart.x", {16'd0, o_x_pos}, 32'd10);
    check_eq("restart.y", {16'd0, o_y_pos}, 32'd20);
    run_pass(0, 1'b0);

    load(13, 22, 10, 20);
    run_pass(0, 1'b1);
    load(5, 5, 5, 7);
    run_pass(0, 1'b0);
    load(3, 3, 3, 3);
    run_pass(0, 1'b0);

    load(900, 700, 790, 590);
    check_eq("clamp.x", {16'd0, o_x_pos}, 32'd790);
    check_eq("clamp.y", {16'd0, o_y_pos}, 32'd590);
    run_pass(0, 1'b0);

    // Rewind mid-pass; new_frame outranks a simultaneous renew_start.
    load(10, 20, 13, 22);
    repeat (4) pulse_renew();
    check_pt("after4", exp_q[4]);
    new_frame = 1'b1;
    renew_start = 1'b1;
    tick();
    new_frame = 1'b0;
    renew_start = 1'b0;
    check_pt("rewind", exp_q[0]);
    run_pass(0, 1'b0);

    // Restart outranks new_frame mid-pass.
    load(10, 20, 13, 22);
    repeat (3) pulse_renew();
    strat_to_output = 1'b1;
    new_frame = 1'b1;
    tick();
    strat_to_output = 1'b0;
    new_frame = 1'b0;
    check_pt("restart_mid", exp_q[0]);

    // rec_start beats renew_start and discards the old box.
    pulse_renew();
    i_x_pos = 16'd50;
    i_y_pos = 16'd60;
    rec_start = 1'b1;
    renew_start = 1'b1;
    tick();
    rec_start = 1'b0;
    renew_start = 1'b0;
    check_off("prio");
    check_eq("prio.done", {31'd0, all_done}, 32'd0);
    pulse_renew();
    pulse_start();
    check_off("have_a_ignore");
    model(50, 60, 52, 61);
    pulse_en(52, 61);
    check_off("prio_armed");
    pulse_start();
    run_pass(0, 1'b0);

    // Asynchronous reset in the middle of EMIT.
    load(10, 20, 13, 22);
    repeat (2) pulse_renew();
    check_pt("pre_rst", exp_q[2]);
    #3 rst = 1'b0;
    #1;
    check_off("async_rst");
    check_eq("async_rst.done", {31'd0, all_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    pulse_renew();
    check_off("post_rst_renew");
    pulse_start();
    check_off("post_rst_start");
    pulse_en(20, 20);
    check_off("post_rst_en");

    // Asynchronous reset while DONE clears all_done immediately.
    load(3, 3, 3, 3);
    pulse_renew();
    check_eq("done_pre_rst", {31'd0, all_done}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check_eq("done_rst.done", {31'd0, all_done}, 32'd0);
    check_off("done_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Random small rectangles across the screen, clamping included.
    for (int t = 0; t < 12; t++) begin
      int ax, ay, bx, by;
      ax = $urandom_range(0, 830);
      ay = $urandom_range(0, 630);
      bx = ax + $urandom_range(0, 8) - 4;
      by = ay + $urandom_range(0, 6) - 3;
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      load(ax, ay, bx, by);
      run_pass(0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
